// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MEM stage: memory op codes, access sizes, bus FSM states.
package mips_defs_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  function automatic mem_size_t op_size(input mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: op_size = SIZE_B;
      MEM_LH, MEM_LHU, MEM_SH: op_size = SIZE_H;
      default:                 op_size = SIZE_W;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_op_t op);
    op_is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic op_is_load(input mem_op_t op);
    op_is_load = (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
                 (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] lo);
    case (op_size(op))
      SIZE_H:  op_misaligned = (op != MEM_NONE) && lo[0];
      SIZE_W:  op_misaligned = (op != MEM_NONE) && (lo != 2'b00);
      default: op_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// SRAM-like two-phase data bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if #(parameter int ADDR_W = 32);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Store lane replication and little-endian load byte/half select with sign/zero extension.
module lsu_align
  import mips_defs_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (op_size(op))
      SIZE_B:  wdata = {4{sdata[7:0]}};
      SIZE_H:  wdata = {2{sdata[15:0]}};
      default: wdata = sdata;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (op)
      MEM_LB:  ldata = {{24{rbyte[7]}}, rbyte};
      MEM_LBU: ldata = {24'd0, rbyte};
      MEM_LH:  ldata = {{16{rhalf[15]}}, rhalf};
      MEM_LHU: ldata = {16'd0, rhalf};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: drives the two-phase data bus, stalls until completion, forwards to MEM/WB.
// Optional MEM_ALIGN_CHECK_EN adds exc_adel/exc_ades and suppresses misaligned accesses.
module mem_stage
  import mips_defs_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [WD_W-1:0]   mem_wd,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_wreg,
  input  logic              mem_whilo,
  input  logic [31:0]       mem_hi,
  input  logic [31:0]       mem_lo,
  input  mem_op_t           mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_sdata,
  mem_stage_if.master       bus,
  output logic [WD_W-1:0]   wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata,
  output logic              wb_whilo,
  output logic [31:0]       wb_hi,
  output logic [31:0]       wb_lo,
  output logic              stallreq_mem
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              exc_adel,
  output logic              exc_ades
`endif
);

  mem_state_t  state_q, state_d;
  mem_size_t   size;
  logic        is_mem, is_load, misalign, go, complete, req;
  logic [1:0]  addr_lo;
  logic [31:0] ld_q, ldata, st_wdata;
  logic        unused_stall;

  assign unused_stall = &{1'b0, stall[5], stall[3:0]};

  assign is_mem  = (mem_op != MEM_NONE);
  assign is_load = op_is_load(mem_op);
  assign size    = op_size(mem_op);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = op_misaligned(mem_op, mem_addr[1:0]);
  assign exc_adel = is_load & misalign;
  assign exc_ades = op_is_store(mem_op) & misalign;
`else
  assign misalign = 1'b0;
`endif

  // Gating with rst keeps req/stall low for the whole reset window, not just after the edge.
  assign go       = is_mem & ~misalign & ~rst;
  assign complete = (state_q == DATA) & bus.data_data_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      if (complete && stall[4]) ld_q <= ldata;
    end
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      IDLE: if (go) begin
        req     = 1'b1;
        state_d = bus.data_addr_ok ? DATA : ADDR;
      end
      ADDR: begin
        req = 1'b1;
        if (bus.data_addr_ok) state_d = DATA;
      end
      DATA: if (bus.data_data_ok) state_d = stall[4] ? DONE : IDLE;
      DONE: if (!stall[4]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (size)
      SIZE_B:  addr_lo = mem_addr[1:0];
      SIZE_H:  addr_lo = {mem_addr[1], 1'b0};
      default: addr_lo = 2'b00;
    endcase
  end

  lsu_align u_align (
    .op      (mem_op),
    .addr_lo (mem_addr[1:0]),
    .sdata   (mem_sdata),
    .rdata   (bus.data_rdata),
    .wdata   (st_wdata),
    .ldata   (ldata)
  );

  assign bus.data_req   = req;
  assign bus.data_wr    = op_is_store(mem_op);
  assign bus.data_size  = size;
  assign bus.data_addr  = {mem_addr[ADDR_W-1:2], addr_lo};
  assign bus.data_wdata = st_wdata;

  assign stallreq_mem = go & (state_q != DONE) & ~complete;

  always_comb begin
    if (complete && is_load)  wb_wdata = ldata;
    else if (state_q == DONE) wb_wdata = ld_q;
    else                      wb_wdata = mem_wdata;
  end

  assign wb_wd    = mem_wd;
  assign wb_wreg  = mem_wreg & ~stallreq_mem & ~misalign;
  assign wb_whilo = mem_whilo;
  assign wb_hi    = mem_hi;
  assign wb_lo    = mem_lo;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with a result scoreboard plus corner sequences.
module tb_mem_stage;
  import mips_defs_pkg::*;

  localparam logic [31:0] ALU = 32'h1357_2468;

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          aok_dly;
    logic        spur;
    logic        wreg;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr;
    logic [31:0] exp_bw;
    logic [31:0] exp_wb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_addr, mem_sdata;
  logic        mem_wreg, mem_whilo;
  mem_op_t     mem_op;
  logic [4:0]  wb_wd;
  logic        wb_wreg, wb_whilo, stallreq_mem;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
`ifdef MEM_ALIGN_CHECK_EN
  logic        exc_adel, exc_ades;
`endif

  int passed = 0;
  int total  = 0;
  logic [31:0] sb[$];
  vec_t vecs[$];

  mem_stage_if #(.ADDR_W(32)) bus ();

  mem_stage #(.ADDR_W(32), .WD_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .mem_wd       (mem_wd),
    .mem_wdata    (mem_wdata),
    .mem_wreg     (mem_wreg),
    .mem_whilo    (mem_whilo),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_sdata    (mem_sdata),
    .bus          (bus),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .wb_whilo     (wb_whilo),
    .wb_hi        (wb_hi),
    .wb_lo        (wb_lo),
    .stallreq_mem (stallreq_mem)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .exc_adel     (exc_adel),
    .exc_ades     (exc_ades)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(input mem_op_t op, input logic [31:0] addr, sdata, rdata,
                              input int aok, input logic spur, input logic wr,
                              input logic [1:0] sz, input logic [31:0] ea, eb, ew);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.aok_dly = aok; v.spur = spur; v.wreg = op_is_load(op);
    v.exp_wr = wr; v.exp_size = sz; v.exp_addr = ea; v.exp_bw = eb; v.exp_wb = ew;
    return v;
  endfunction

  // Drives one transaction; the slave accepts the address after aok_dly extra cycles and
  // returns data in the first DATA cycle. Called on a negedge, returns on a negedge.
  task automatic run_txn(input vec_t v);
    int stalls;
    logic [31:0] exp;
    mem_op = v.op; mem_addr = v.addr; mem_sdata = v.sdata;
    mem_wreg = v.wreg; mem_wdata = ALU; stall = '0;
    sb.push_back(v.exp_wb);
    stalls = 0;
    for (int k = 0; k <= v.aok_dly; k++) begin
      bus.data_addr_ok = (k == v.aok_dly);
      bus.data_data_ok = v.spur;
      bus.data_rdata   = 32'h0BAD_BAD0;
      #1;
      if (k == 0) begin
        chk("bus_wr",    32'(bus.data_wr),   32'(v.exp_wr));
        chk("bus_size",  32'(bus.data_size), 32'(v.exp_size));
        chk("bus_addr",  bus.data_addr,      v.exp_addr);
        chk("bus_wdata", bus.data_wdata,     v.exp_bw);
`ifdef MEM_ALIGN_CHECK_EN
        chk("exc_none",  32'({exc_adel, exc_ades}), 32'd0);
`endif
      end
      chk("req_addr_phase",  32'(bus.data_req), 32'd1);
      chk("wreg_while_stall", 32'(wb_wreg),     32'd0);
      if (stallreq_mem) stalls++;
      @(negedge clk);
    end
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    #1;
    chk("req_data_phase",   32'(bus.data_req),     32'd0);
    chk("stall_data_phase", 32'(stallreq_mem),     32'd1);
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = v.rdata;
    #1;
    chk("stall_on_done", 32'(stallreq_mem), 32'd0);
    chk("wreg_on_done",  32'(wb_wreg),      32'(v.wreg));
    if (sb.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
    else begin
      exp = sb.pop_front();
      chk("wb_wdata", wb_wdata, exp);
    end
    chk("stall_cycles", 32'(stalls), 32'(v.aok_dly + 1));
    @(negedge clk);
    bus.data_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = '0; mem_wd = '0; mem_wdata = '0; mem_wreg = 1'b0;
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0; mem_op = MEM_NONE;
    mem_addr = '0; mem_sdata = '0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;

    vecs.push_back(mk(MEM_LW,  32'h100, 32'h0,         32'hDEADBEEF, 1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0,         32'hDEADBEEF));
    vecs.push_back(mk(MEM_LB,  32'h103, 32'h0,         32'h80FFFF7F, 0, 1'b0, 1'b0, 2'd0, 32'h103, 32'h0,         32'hFFFFFF80));
    vecs.push_back(mk(MEM_LBU, 32'h103, 32'h0,         32'h80FFFF7F, 0, 1'b0, 1'b0, 2'd0, 32'h103, 32'h0,         32'h00000080));
    vecs.push_back(mk(MEM_SH,  32'h202, 32'h1234ABCD,  32'h0,        0, 1'b0, 1'b1, 2'd1, 32'h202, 32'hABCDABCD,  ALU));
    vecs.push_back(mk(MEM_LH,  32'h102, 32'h0,         32'h80017FFF, 1, 1'b0, 1'b0, 2'd1, 32'h102, 32'h0,         32'hFFFF8001));
    vecs.push_back(mk(MEM_LHU, 32'h100, 32'h0,         32'h8001F00F, 0, 1'b0, 1'b0, 2'd1, 32'h100, 32'h0,         32'h0000F00F));
    vecs.push_back(mk(MEM_LB,  32'h101, 32'h0,         32'h00007F00, 2, 1'b1, 1'b0, 2'd0, 32'h101, 32'h0,         32'h0000007F));
    vecs.push_back(mk(MEM_SB,  32'h305, 32'h000000A5,  32'h0,        0, 1'b0, 1'b1, 2'd0, 32'h305, 32'hA5A5A5A5,  ALU));
    vecs.push_back(mk(MEM_SW,  32'h404, 32'hCAFEF00D,  32'h0,        0, 1'b1, 1'b1, 2'd2, 32'h404, 32'hCAFEF00D,  ALU));
    vecs.push_back(mk(MEM_LW,  32'h200, 32'h0,         32'h01234567, 3, 1'b1, 1'b0, 2'd2, 32'h200, 32'h0,         32'h01234567));
`ifndef MEM_ALIGN_CHECK_EN
    vecs.push_back(mk(MEM_LW,  32'h106, 32'h0,         32'h89ABCDEF, 0, 1'b0, 1'b0, 2'd2, 32'h104, 32'h0,         32'h89ABCDEF));
    vecs.push_back(mk(MEM_LH,  32'h103, 32'h0,         32'h80017FFF, 0, 1'b0, 1'b0, 2'd1, 32'h102, 32'h0,         32'hFFFF8001));
    vecs.push_back(mk(MEM_SW,  32'h40B, 32'h12345678,  32'h0,        0, 1'b0, 1'b1, 2'd2, 32'h408, 32'h12345678,  ALU));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   32'(bus.data_req), 32'd0);
    chk("rst_stall", 32'(stallreq_mem), 32'd0);
    chk("rst_wb",    {wb_wdata[15:0], 8'(wb_wd), 6'd0, wb_wreg, wb_whilo}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU op passes straight through
    mem_op = MEM_NONE; mem_wd = 5'h1F; mem_wdata = 32'hA5A55A5A; mem_wreg = 1'b1;
    mem_whilo = 1'b1; mem_hi = 32'h1111_0000; mem_lo = 32'h0000_2222;
    #1;
    chk("alu_stall", 32'(stallreq_mem), 32'd0);
    chk("alu_req",   32'(bus.data_req), 32'd0);
    chk("alu_wdata", wb_wdata,          32'hA5A55A5A);
    chk("alu_wd",    32'(wb_wd),        32'h1F);
    chk("alu_wreg",  32'(wb_wreg),      32'd1);
    chk("alu_whilo", 32'(wb_whilo),     32'd1);
    chk("alu_hi",    wb_hi,             32'h1111_0000);
    chk("alu_lo",    wb_lo,             32'h0000_2222);
    @(negedge clk);

    // Back-to-back table vectors
    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

    // LW completing under stall[4]: DONE holds the loaded value, no re-request
    mem_op = MEM_LW; mem_addr = 32'h108; mem_wreg = 1'b1; mem_wdata = ALU; stall = '0;
    bus.data_addr_ok = 1'b1;
    #1 chk("hold_req", 32'(bus.data_req), 32'd1);
    @(negedge clk);
    bus.data_addr_ok = 1'b0; stall[4] = 1'b1;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h11223344;
    #1 chk("hold_done_wdata", wb_wdata, 32'h11223344);
    @(negedge clk);
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_no_req",  32'(bus.data_req), 32'd0);
      chk("hold_nostall", 32'(stallreq_mem), 32'd0);
      chk("hold_ldq",     wb_wdata,          32'h11223344);
      chk("hold_wreg",    32'(wb_wreg),      32'd1);
      @(negedge clk);
    end
    stall[4] = 1'b0;
    #1 chk("hold_release_ldq", wb_wdata, 32'h11223344);
    @(negedge clk);
    mem_op = MEM_NONE; mem_wdata = 32'h0000_0077;
    #1 chk("hold_back_idle", wb_wdata, 32'h0000_0077);
    @(negedge clk);

    // Async reset in DATA
    mem_op = MEM_LW; mem_addr = 32'h10C; mem_wreg = 1'b1;
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    #1 chk("pre_rst_stall", 32'(stallreq_mem), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req",   32'(bus.data_req), 32'd0);
    chk("rst_mid_stall", 32'(stallreq_mem), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_op = MEM_NONE; mem_wdata = 32'h0000_0099;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBEEF_0000;
    #1;
    chk("post_rst_stall", 32'(stallreq_mem), 32'd0);
    chk("post_rst_wdata", wb_wdata,          32'h0000_0099);
    chk("post_rst_wreg",  32'(wb_wreg),      32'd1);
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    run_txn(vecs[0]);

`ifdef MEM_ALIGN_CHECK_EN
    mem_op = MEM_LW; mem_addr = 32'h101; mem_wreg = 1'b1;
    #1;
    chk("adel_flag",  32'(exc_adel),      32'd1);
    chk("adel_ades",  32'(exc_ades),      32'd0);
    chk("adel_req",   32'(bus.data_req),  32'd0);
    chk("adel_stall", 32'(stallreq_mem),  32'd0);
    chk("adel_wreg",  32'(wb_wreg),       32'd0);
    @(negedge clk);
    mem_op = MEM_SH; mem_addr = 32'h201; mem_wreg = 1'b0;
    #1;
    chk("ades_flag",  32'(exc_ades),      32'd1);
    chk("ades_req",   32'(bus.data_req),  32'd0);
    @(negedge clk);
    mem_op = MEM_NONE;
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
